// File: rtl/uart_byte_rx_pkg.sv
// Shared definitions for the UART byte receiver: state encoding, default line settings,
// bit-timing formula and the even-parity helper.
package uart_byte_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } rx_state_e;

  localparam int unsigned DEF_CLK_FREQ  = 32'd50_000_000;
  localparam int unsigned DEF_BAUD_RATE = 32'd115_200;

  // Clocks per bit; shared with the matching transmitter.
  function automatic int unsigned bit_cycles(input int unsigned clk_freq, input int unsigned baud);
    return clk_freq / baud;
  endfunction

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_byte_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line; both flops reset to 1 (idle line).
module uart_byte_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_i,
  output logic rx_s_o
);

  logic meta_q;
  logic sync_q;

  // Double-register the raw line into the clk domain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
    end
  end

  assign rx_s_o = sync_q;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver feeding the byte packer; define UART_RX_PARITY_EN for 8E1 framing
// with a parity_error strobe (otherwise parity_error is tied low).
module uart_byte_rx
  import uart_byte_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = DEF_CLK_FREQ,
  parameter int unsigned BAUD_RATE = DEF_BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_8,
  output logic       data_out_enable,
  output logic       frame_error,
  output logic       parity_error,
  output logic       rx_busy
);

  localparam int unsigned BIT_CYCLES  = bit_cycles(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_CYCLES = BIT_CYCLES / 2;
  localparam int          CNT_W       = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  rx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shreg_q;
  logic             rx_s;
  logic             sample_s;

  uart_byte_rx_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_i   (rx),
    .rx_s_o (rx_s)
  );

  // START samples mid-bit to find the centre; every later bit is one full period on.
  assign sample_s = (state_q == S_START) ? (cnt_q == HALF_LAST) : (cnt_q == BIT_LAST);
  assign rx_busy  = (state_q != S_IDLE);

`ifdef UART_RX_PARITY_EN
  logic perr_q;
  logic parity_error_q;
  assign parity_error = parity_error_q;
`else
  assign parity_error = 1'b0;
`endif

  // Frame FSM with counters, shift register and registered output strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      bit_idx_q       <= 3'd0;
      shreg_q         <= 8'd0;
      data_8          <= 8'd0;
      data_out_enable <= 1'b0;
      frame_error     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q          <= 1'b0;
      parity_error_q  <= 1'b0;
`endif
    end else begin
      data_out_enable <= 1'b0;
      frame_error     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error_q  <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (!rx_s) begin
            state_q <= S_START;
          end
        end
        S_START: begin
          if (sample_s) begin
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            state_q   <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_DATA: begin
          if (sample_s) begin
            cnt_q              <= '0;
            shreg_q[bit_idx_q] <= rx_s;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (sample_s) begin
            cnt_q   <= '0;
            perr_q  <= (rx_s != even_parity(shreg_q));
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
`endif
        S_STOP: begin
          // Leave at mid-stop so a following start edge is never missed.
          if (sample_s) begin
            cnt_q       <= '0;
            state_q     <= S_IDLE;
            frame_error <= ~rx_s;
`ifdef UART_RX_PARITY_EN
            parity_error_q <= perr_q;
            perr_q         <= 1'b0;
            if (rx_s && !perr_q) begin
              data_8          <= shreg_q;
              data_out_enable <= 1'b1;
            end
`else
            if (rx_s) begin
              data_8          <= shreg_q;
              data_out_enable <= 1'b1;
            end
`endif
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx: a default-rate instance for latency/glitch/framing,
// and a fast-baud instance for back-to-back, table, reset and randomized frames.
module tb_uart_byte_rx;

  localparam int DEF_BC   = 50_000_000 / 115_200;
  localparam int DEF_HALF = DEF_BC / 2;
  localparam int F_BC     = 16;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst_n_a = 1'b0, rx_a = 1'b1;
  logic       rst_n_b = 1'b0, rx_b = 1'b1;
  logic [7:0] data_8_a, data_8_b;
  logic       doe_a, doe_b, ferr_a, ferr_b, perr_a, perr_b, busy_a, busy_b;

  uart_byte_rx dut_a (
    .clk(clk), .rst_n(rst_n_a), .rx(rx_a), .data_8(data_8_a), .data_out_enable(doe_a),
    .frame_error(ferr_a), .parity_error(perr_a), .rx_busy(busy_a)
  );

  uart_byte_rx #(.CLK_FREQ(50_000_000), .BAUD_RATE(3_125_000)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .rx(rx_b), .data_8(data_8_b), .data_out_enable(doe_b),
    .frame_error(ferr_b), .parity_error(perr_b), .rx_busy(busy_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strb_a = 0, ferr_cnt_a = 0, perr_cnt_a = 0, both_a = 0, last_strb_cyc_a = 0;
  int strb_b = 0, ferr_cnt_b = 0, perr_cnt_b = 0, both_b = 0;
  logic [7:0] got_b[$];

  always @(posedge clk) cyc++;

  // Event monitors sample on the falling edge.
  always @(negedge clk) begin
    if (doe_a) begin strb_a++; last_strb_cyc_a = cyc; end
    if (ferr_a) ferr_cnt_a++;
    if (perr_a) perr_cnt_a++;
    if (doe_a && ferr_a) both_a++;
    if (doe_b) begin strb_b++; got_b.push_back(data_8_b); end
    if (ferr_b) ferr_cnt_b++;
    if (perr_b) perr_cnt_b++;
    if (doe_b && ferr_b) both_b++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic drive_bit(input bit sel, input logic v, input int n);
    if (sel) rx_b = v; else rx_a = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame_p(input bit sel, input logic [7:0] b, input logic stop_v, input logic par_v);
    int bc;
    bc = sel ? F_BC : DEF_BC;
    drive_bit(sel, 1'b0, bc);
    for (int i = 0; i < 8; i++) drive_bit(sel, b[i], bc);
`ifdef UART_RX_PARITY_EN
    drive_bit(sel, par_v, bc);
`else
    if (par_v !== (^b)) drive_bit(sel, 1'b1, 0);
`endif
    drive_bit(sel, stop_v, bc);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] b, input logic stop_v);
    send_frame_p(sel, b, stop_v, ^b);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_strb;
    int         exp_ferr;
    logic [7:0] exp_d8;
  } vec_t;

  vec_t vecs[7];
  logic [7:0] b2b[16];
  logic [63:0] w0, w1;
  int s0, f0, c0, busy_cnt;
  logic [7:0] model_d8, rb;
  logic rstop;

  initial begin
    vecs[0] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[1] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[2] = '{8'h80, 1'b0, 0, 1, 8'hFF};
    vecs[3] = '{8'h01, 1'b1, 1, 0, 8'h01};
    vecs[4] = '{8'h55, 1'b1, 1, 0, 8'h55};
    vecs[5] = '{8'hAA, 1'b0, 0, 1, 8'h55};
    vecs[6] = '{8'h3C, 1'b1, 1, 0, 8'h3C};
    b2b = '{8'hd7, 8'ha7, 8'h01, 8'ha0, 8'hc4, 8'h04, 8'h27, 8'hcb,
            8'h46, 8'h4d, 8'h74, 8'h9a, 8'hfa, 8'h03, 8'h74, 8'h23};

    repeat (3) @(negedge clk);
    check("reset_a", {data_8_a, doe_a, ferr_a, perr_a, busy_a}, 64'd0);
    check("reset_b", {data_8_b, doe_b, ferr_b, perr_b, busy_b}, 64'd0);
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte at default rate with latency window.
    s0 = strb_a; c0 = cyc;
    send_frame(1'b0, 8'hD7, 1'b1);
    repeat (4) @(negedge clk);
    check("single_count", strb_a - s0, 1);
    check("single_data", data_8_a, 8'hD7);
    check_range("single_latency", last_strb_cyc_a - c0, 2 + DEF_HALF + 9 * DEF_BC - 1, 2 + DEF_HALF + 9 * DEF_BC + 1);

    // Start-bit glitch of five clocks.
    s0 = strb_a; f0 = ferr_cnt_a; busy_cnt = 0;
    rx_a = 1'b0;
    for (int i = 0; i < DEF_BC; i++) begin
      if (i == 5) rx_a = 1'b1;
      @(negedge clk);
      if (busy_a) busy_cnt++;
    end
    check_range("glitch_busy", busy_cnt, DEF_HALF - 1, DEF_HALF + 2);
    check("glitch_idle", busy_a, 1'b0);
    check("glitch_nostrobe", (strb_a - s0) + (ferr_cnt_a - f0), 0);
    check("glitch_data", data_8_a, 8'hD7);

    // Bad stop bit, then a good frame.
    s0 = strb_a; f0 = ferr_cnt_a;
    send_frame(1'b0, 8'h55, 1'b0);
    drive_bit(1'b0, 1'b1, DEF_BC);
    check("frame_err_count", ferr_cnt_a - f0, 1);
    check("frame_err_nostrobe", strb_a - s0, 0);
    check("frame_err_data", data_8_a, 8'hD7);
    s0 = strb_a; f0 = ferr_cnt_a;
    send_frame(1'b0, 8'hA7, 1'b1);
    repeat (4) @(negedge clk);
    check("after_ferr_count", strb_a - s0, 1);
    check("after_ferr_data", data_8_a, 8'hA7);
    check("after_ferr_noerr", ferr_cnt_a - f0, 0);

    // Sixteen back-to-back frames on the fast instance.
    got_b.delete(); f0 = ferr_cnt_b;
    foreach (b2b[i]) send_frame(1'b1, b2b[i], 1'b1);
    repeat (2 * F_BC) @(negedge clk);
    check("b2b_count", got_b.size(), 16);
    check("b2b_ferr", ferr_cnt_b - f0, 0);
    w0 = '0; w1 = '0;
    if (got_b.size() == 16) begin
      for (int i = 0; i < 8; i++) begin
        w0[i*8 +: 8] = got_b[i];
        w1[i*8 +: 8] = got_b[i+8];
      end
    end
    check("b2b_word0", w0, 64'hcb2704c4a001a7d7);
    check("b2b_word1", w1, 64'h237403fa9a744d46);

    // Table of single frames with an idle bit after each.
    foreach (vecs[i]) begin
      s0 = strb_b; f0 = ferr_cnt_b;
      send_frame(1'b1, vecs[i].data, vecs[i].stop);
      drive_bit(1'b1, 1'b1, F_BC);
      check($sformatf("vec%0d_strobe", i), strb_b - s0, vecs[i].exp_strb);
      check($sformatf("vec%0d_ferr", i), ferr_cnt_b - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d_data", i), data_8_b, vecs[i].exp_d8);
    end

    // Reset during data bit 4 of 0x46.
    s0 = strb_b;
    drive_bit(1'b1, 1'b0, F_BC);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, (8'h46 >> i) & 8'h01, F_BC);
    drive_bit(1'b1, 1'b0, F_BC / 2);
    check("pre_reset_busy", busy_b, 1'b1);
    rst_n_b = 1'b0; rx_b = 1'b1;
    @(negedge clk);
    check("mid_reset_outputs", {data_8_b, doe_b, ferr_b, perr_b, busy_b}, 64'd0);
    @(negedge clk);
    rst_n_b = 1'b1;
    drive_bit(1'b1, 1'b1, 12 * F_BC);
    check("reset_discard", strb_b - s0, 0);
    send_frame(1'b1, 8'h4D, 1'b1);
    drive_bit(1'b1, 1'b1, F_BC);
    check("post_reset_data", data_8_b, 8'h4D);
    check("post_reset_count", strb_b - s0, 1);

`ifdef UART_RX_PARITY_EN
    send_frame(1'b1, 8'h11, 1'b1);
    drive_bit(1'b1, 1'b1, F_BC);
    s0 = strb_b; f0 = perr_cnt_b;
    send_frame_p(1'b1, 8'h4D, 1'b1, 1'b1);
    drive_bit(1'b1, 1'b1, F_BC);
    check("parity_err_count", perr_cnt_b - f0, 1);
    check("parity_err_nostrobe", strb_b - s0, 0);
    check("parity_err_data", data_8_b, 8'h11);
    send_frame_p(1'b1, 8'h4D, 1'b1, 1'b0);
    drive_bit(1'b1, 1'b1, F_BC);
    check("parity_ok_data", data_8_b, 8'h4D);
    check("parity_ok_count", strb_b - s0, 1);
`endif

    // Randomized frames against a frame-level model.
    model_d8 = data_8_b;
    for (int n = 0; n < 40; n++) begin
      rb = 8'($urandom);
      rstop = ($urandom_range(0, 3) != 0);
      s0 = strb_b; f0 = ferr_cnt_b;
      send_frame(1'b1, rb, rstop);
      if (rstop) model_d8 = rb;
      check($sformatf("rnd%0d_strobe", n), strb_b - s0, rstop ? 1 : 0);
      check($sformatf("rnd%0d_ferr", n), ferr_cnt_b - f0, rstop ? 0 : 1);
      check($sformatf("rnd%0d_data", n), data_8_b, model_d8);
      drive_bit(1'b1, 1'b1, (rstop ? 0 : F_BC) + $urandom_range(0, 20));
    end

    check("never_both_a", both_a, 0);
    check("never_both_b", both_b, 0);
`ifndef UART_RX_PARITY_EN
    check("parity_tied_low", perr_cnt_a + perr_cnt_b, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
